ex_divider: RTL and testbench
=============================

# ex_divider

Multi-cycle 32-bit radix-2 restoring divider in the EX stage; it is the requesting side of the pipeline stall protocol. While a divide occupies EX it drives `stallreq_for_ex` so that CTRL freezes the front of the pipeline. It releases the request in the cycle its quotient and remainder are ready. Results feed the HI/LO write path: remainder goes to HI, quotient to LO.

## Interface
Parameters:
- `DATA_W`, default 32: operand width. The result is 2*DATA_W; iterations equal DATA_W.

Ports:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `div_start`  in  1  EX holds a valid div/divu; held high by the stalled EX register until `ready`
- `signed_div`  in  1  1 = div (two's complement), 0 = divu
- `opdata1`  in  DATA_W  dividend
- `opdata2`  in  DATA_W  divisor
- `annul`  in  1  cancel the operation in flight (flush/exception)
- `result`  out  2*DATA_W  {remainder, quotient}
- `ready`  out  1  one-cycle pulse; `result` is valid
- `stallreq_for_ex`  out  1  stall request to CTRL

## Operation
- State machine has four states: IDLE, DIVZERO, ON, END.
- **IDLE:**
  - On `div_start` & !`annul`, latch the operands.
  - If the divisor is 0, go to DIVZERO. Otherwise go to ON with count = 0.
  - Signed mode takes magnitudes first: |x| of 0x80000000 is 0x80000000, read as unsigned.
- **DIVZERO:** result := 0 (quotient 0, remainder 0), then go to END.
- **ON:** one shift-subtract step per cycle on a (2*DATA_W+1)-bit partial remainder. After step DATA_W-1, apply sign fix-up and go to END.
- **Sign fix-up (signed only):**
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative.
  - Results wrap mod 2^DATA_W, so 0x80000000 / −1 gives quotient 0x80000000, remainder 0.
- **END:** `ready` = 1, then go unconditionally to IDLE.
- **Outputs:**
  - `result` is registered and holds its value until the next result is produced.
  - `ready` is registered.
  - `stallreq_for_ex` = `div_start` & !`annul` & (state != END). It is combinational, so it is already high in the issue cycle.
- **annul:** in any state, go to IDLE on the next edge. `ready` is never pulsed for the annulled operation and `result` is left unchanged.
- **Back-to-back divides:** the next EX instruction's `div_start` can be seen in IDLE on the cycle right after END. It is accepted with no bubble beyond the IDLE issue cycle.
- **Reset** (asserted at any point, including mid-ON): state IDLE, count 0, `result` 0, `ready` 0. `stallreq_for_ex` follows its equation.

## Timing
- Cycle 0: `div_start` is seen in IDLE and `stallreq_for_ex` = 1.
- Normal divide:
  - ON occupies cycles 1..32.
  - END falls in cycle 33: `ready` = 1 and `stallreq_for_ex` = 0.
  - The EX/MEM register captures `result` at the end of cycle 33.
- Divide by zero: DIVZERO in cycle 1, END in cycle 2.
- Total stall: 33 cycles for a normal divide, 2 cycles for divide by zero.
- `div_start` dropping without `annul` while in ON is a protocol violation. The block still completes and pulses `ready`.

## Structure
- The following are added to `lib/defines.vh` next to `StallBus`/`Stop`/`NoStop`:
  - state encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2 bits)
  - `DivResultReady` / `DivResultNotReady`
- No sub-module is needed. A small `div_abs` function or inline expression covers the magnitude and negate steps.
- Instantiated inside EX, which ORs `stallreq_for_ex` with any other EX stall sources going to CTRL.

## Test plan
- divu 7 / 2 → cycle 33: `ready` = 1, `result` = {0x00000001, 0x00000003}; `stallreq_for_ex` high in cycles 0–32, low in cycle 33.
- div −7 / 2 (0xFFFFFFF9, 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF at cycle 33.
- div 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0; divu 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- divu 5 / 0 → `ready` at cycle 2, `result` 0; stall lasts exactly 2 cycles.
- divu 100 / 3 with `annul` pulsed at cycle 10 → IDLE at cycle 11, no `ready`, `result` keeps its prior value; a following divu 9 / 4 completes with quotient 2, remainder 1.
- Async `rst` asserted mid-ON (cycle 15, between edges) → state, `result` and `ready` clear immediately. After release, two back-to-back divides (8/2, then 9/3) both return correct results, the second issuing in the cycle after the first's END.

Source files
------------

// File: rtl/ex_divider_pkg.sv
// Shared encodings for the EX-stage divider: FSM states and ready levels.
package ex_divider_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/ex_divider.sv
// Radix-2 restoring divider for the EX stage; holds the pipeline via stallreq_for_ex
// until {remainder, quotient} is ready.
module ex_divider
  import ex_divider_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_start,
  input  logic                  signed_div,
  input  logic [DATA_W-1:0]     opdata1,
  input  logic [DATA_W-1:0]     opdata2,
  input  logic                  annul,
  output logic [2*DATA_W-1:0]   result,
  output logic                  ready,
  output logic                  stallreq_for_ex
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [2*DATA_W:0]     pr_q, pr_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  quot_neg_q, quot_neg_d;
  logic                  rem_neg_q, rem_neg_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic [DATA_W-1:0]     a_mag, b_mag;
  logic [DATA_W:0]       diff;
  logic [2*DATA_W:0]     pr_step;
  logic [DATA_W-1:0]     quot_raw, rem_raw;

  // Magnitudes in two's complement; the most negative value maps onto itself,
  // which is the correct unsigned magnitude.
  assign a_mag = (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
  assign b_mag = (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;

  // pr holds {remainder, dividend/quotient, guard}; bit 0 receives each quotient bit.
  assign diff    = {1'b0, pr_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
  assign pr_step = diff[DATA_W] ? {pr_q[2*DATA_W-1:0], 1'b0}
                                : {diff[DATA_W-1:0], pr_q[DATA_W-1:0], 1'b1};
  assign quot_raw = pr_step[DATA_W-1:0];
  assign rem_raw  = pr_step[2*DATA_W:DATA_W+1];

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pr_d       = pr_q;
    divisor_d  = divisor_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    result_d   = result_q;
    ready_d    = DivResultNotReady;

    case (state_q)
      DivFree: begin
        if (div_start && !annul) begin
          divisor_d  = b_mag;
          pr_d       = {{DATA_W{1'b0}}, a_mag, 1'b0};
          quot_neg_d = signed_div && (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
          rem_neg_d  = signed_div && opdata1[DATA_W-1];
          count_d    = '0;
          state_d    = (opdata2 == '0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        result_d = '0;
        ready_d  = DivResultReady;
        state_d  = DivEnd;
      end
      DivOn: begin
        pr_d    = pr_step;
        count_d = count_q + 1'b1;
        if (count_q == LAST_STEP) begin
          result_d = {rem_neg_q ? -rem_raw : rem_raw,
                      quot_neg_q ? -quot_raw : quot_raw};
          ready_d  = DivResultReady;
          count_d  = '0;
          state_d  = DivEnd;
        end
      end
      DivEnd: begin
        state_d = DivFree;
      end
      default: state_d = DivFree;
    endcase

    // A flush wins over everything: no ready pulse, result untouched.
    if (annul) begin
      state_d  = DivFree;
      count_d  = '0;
      result_d = result_q;
      ready_d  = DivResultNotReady;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DivFree;
      count_q    <= '0;
      pr_q       <= '0;
      divisor_q  <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pr_q       <= pr_d;
      divisor_q  <= divisor_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result          = result_q;
  assign ready           = ready_q;
  assign stallreq_for_ex = div_start && !annul && (state_q != DivEnd);

endmodule

// File: tb/tb_ex_divider.sv
// Directed bench for ex_divider: cycle-exact stall/ready timing and results.
module tb_ex_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq_for_ex;

  int passes = 0;
  int total  = 0;

  ex_divider #(.DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .div_start       (div_start),
    .signed_div      (signed_div),
    .opdata1         (opdata1),
    .opdata2         (opdata2),
    .annul           (annul),
    .result          (result),
    .ready           (ready),
    .stallreq_for_ex (stallreq_for_ex)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with the DUT in IDLE. Issues the divide in
  // cycle 0 and expects ready exactly in cycle lat, stall high in cycles 0..lat-1.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [63:0] exp_res);
    logic busy_ok;
    busy_ok    = 1'b1;
    div_start  = 1'b1;
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    for (int cyc = 0; cyc < lat; cyc++) begin
      @(negedge clk);
      if (stallreq_for_ex !== 1'b1 || ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk({tag, ".busy"}, {63'd0, busy_ok}, 64'd1);
    chk({tag, ".ready"}, {63'd0, ready}, 64'd1);
    chk({tag, ".stall_end"}, {63'd0, stallreq_for_ex}, 64'd0);
    chk({tag, ".result"}, result, exp_res);
    $display("divide %s: a=%h b=%h signed=%0d result=%h ready=%0d", tag, a, b, sgn, result, ready);
    @(posedge clk);
    #1;
    div_start = 1'b0;
  endtask

  initial begin
    logic [63:0] held;
    logic        ready_seen;

    rst        = 1'b1;
    div_start  = 1'b0;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    annul      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.result", result, 64'd0);
    chk("reset.ready", {63'd0, ready}, 64'd0);
    chk("reset.stall", {63'd0, stallreq_for_ex}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_div("divu_7_2", 1'b0, 32'd7, 32'd2, 33, {32'd1, 32'd3});
    @(negedge clk);
    chk("divu_7_2.ready_pulse", {63'd0, ready}, 64'd0);
    @(posedge clk);
    #1;

    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_div("divu_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 33, {32'd1, 32'h7FFF_FFFC});
    do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'd0, 32'h8000_0000});
    do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, {32'd0, 32'hFFFF_FFFF});
    do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 2, 64'd0);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD});

    // Annul in cycle 10 of divu 100/3; the held result is that of 7 / -2.
    held       = {32'd1, 32'hFFFF_FFFD};
    div_start  = 1'b1;
    signed_div = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    @(negedge clk);
    chk("annul.stall_low", {63'd0, stallreq_for_ex}, 64'd0);
    @(posedge clk);
    #1;
    annul     = 1'b0;
    div_start = 1'b0;
    ready_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready === 1'b1) ready_seen = 1'b1;
    end
    chk("annul.no_ready", {63'd0, ready_seen}, 64'd0);
    chk("annul.result_held", result, held);
    @(posedge clk);
    #1;
    do_div("divu_9_4", 1'b0, 32'd9, 32'd4, 33, {32'd1, 32'd2});

    // Asynchronous reset between edges in cycle 15 of divu 50/7.
    div_start  = 1'b1;
    signed_div = 1'b0;
    opdata1    = 32'd50;
    opdata2    = 32'd7;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid.result", result, 64'd0);
    chk("rst_mid.ready", {63'd0, ready}, 64'd0);
    div_start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back: the second issues in the cycle right after the first's END.
    do_div("b2b_8_2", 1'b0, 32'd8, 32'd2, 33, {32'd0, 32'd4});
    do_div("b2b_9_3", 1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3});
    @(negedge clk);
    chk("b2b.idle_ready", {63'd0, ready}, 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
